// File: rtl/rv32_pkg.sv
// Shared RV32IM decode definitions: opcodes, the canonical NOP, the ALU
// operation / operand-select / writeback-select encodings seen by execute,
// and the immediate generator used by decode.
package rv32_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17,
    ALU_PASS_B = 5'd18
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_t;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_t;

  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_MEM     = 2'd1,
    WB_PC_PLUS = 2'd2
  } wb_sel_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_fmt_t;

  // Every format except U is sign-extended from inst[31].
  function automatic logic signed [31:0] imm_gen(input logic [31:0] inst,
                                                 input imm_fmt_t    fmt);
    logic signed [31:0] imm;
    case (fmt)
      IMM_S:   imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{21{inst[31]}}, inst[30:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_pipe_reg_file.sv
// 2-read / 1-write architectural register file.
//   Clk_Core, Rst_Core_N : clock, async active-low reset (clears all entries)
//   rs1_addr / rs2_addr  : async read addresses
//   rs1_data / rs2_data  : read data; x0 reads 0, a same-cycle write bypasses
//   wr_en / wr_addr / wr_data : synchronous write port (writes to x0 dropped)
module reg_file #(
  parameter int DWIDTH   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic [AW-1:0]     rs1_addr,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DWIDTH-1:0] rs1_data,
  output logic [DWIDTH-1:0] rs2_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DWIDTH-1:0] wr_data
);

  logic [DWIDTH-1:0] regs_q [NUM_REGS];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Bypass lets decode see a value retiring in the same cycle.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0)                        rs1_data = '0;
    else if (wr_live && (wr_addr == rs1_addr)) rs1_data = wr_data;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0)                        rs2_data = '0;
    else if (wr_live && (wr_addr == rs2_addr)) rs2_data = wr_data;
  end

endmodule

// File: rtl/decode_pipe.sv
// RV32IM decode stage and decode/execute pipeline register.
//   Clk_Core, Rst_Core_N          : clock, async active-low reset
//   instruct_di, pc_di, pc_plus_di: fetch outputs
//   flush_di                      : redirect from execute, loads a bubble
//   stall_do                      : load-use stall back to fetch (combinational)
//   wb_en_di, wb_rd_di, wb_data_di: register file write port from writeback
//   *_do                          : registered control and operands for execute
module decode_pipe
  import rv32_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic [31:0]       instruct_di,
  input  logic [DWIDTH-1:0] pc_di,
  input  logic [DWIDTH-1:0] pc_plus_di,
  input  logic              flush_di,
  output logic              stall_do,
  input  logic              wb_en_di,
  input  logic [4:0]        wb_rd_di,
  input  logic [DWIDTH-1:0] wb_data_di,
  output logic [DWIDTH-1:0] pc_do,
  output logic [DWIDTH-1:0] pc_plus_do,
  output logic [DWIDTH-1:0] rs1_data_do,
  output logic [DWIDTH-1:0] rs2_data_do,
  output logic [31:0]       imm_do,
  output logic [4:0]        rs1_addr_do,
  output logic [4:0]        rs2_addr_do,
  output logic [4:0]        rd_do,
  output logic [4:0]        alu_op_do,
  output logic [1:0]        alu_src_a_do,
  output logic              alu_src_b_do,
  output logic              mem_read_do,
  output logic              mem_write_do,
  output logic [2:0]        mem_size_do,
  output logic              reg_write_do,
  output logic [1:0]        wb_sel_do,
  output logic              branch_do,
  output logic              jal_do,
  output logic              jalr_do,
  output logic [2:0]        br_funct3_do,
  output logic              illegal_do
);

  function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_t muldiv_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100:  return ALU_DIV;
      3'b101:  return ALU_DIVU;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

  // Stage p0: combinational decode of the fetch outputs
  logic [6:0]         opcode_p0;
  logic [2:0]         funct3_p0;
  logic [6:0]         funct7_p0;
  alu_op_t            alu_op_p0;
  src_a_t             src_a_p0;
  src_b_t             src_b_p0;
  wb_sel_t            wb_sel_p0;
  imm_fmt_t           imm_fmt_p0;
  logic               mem_read_p0, mem_write_p0, reg_write_p0;
  logic               branch_p0, jal_p0, jalr_p0, illegal_p0;
  logic               rs1_used_p0, rs2_used_p0;
  logic [4:0]         rs1_addr_p0, rs2_addr_p0, rd_p0;
  logic signed [31:0] imm_p0;
  logic [DWIDTH-1:0]  rs1_data_p0, rs2_data_p0;
  logic               hazard_p0, kill_p0;

  assign opcode_p0 = instruct_di[6:0];
  assign funct3_p0 = instruct_di[14:12];
  assign funct7_p0 = instruct_di[31:25];

  always_comb begin
    alu_op_p0    = ALU_ADD;
    src_a_p0     = SRC_A_RS1;
    src_b_p0     = SRC_B_RS2;
    wb_sel_p0    = WB_ALU;
    imm_fmt_p0   = IMM_I;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    reg_write_p0 = 1'b0;
    branch_p0    = 1'b0;
    jal_p0       = 1'b0;
    jalr_p0      = 1'b0;
    illegal_p0   = 1'b0;
    rs1_used_p0  = 1'b0;
    rs2_used_p0  = 1'b0;
    case (opcode_p0)
      OPC_LUI: begin
        alu_op_p0 = ALU_PASS_B; src_a_p0 = SRC_A_ZERO; src_b_p0 = SRC_B_IMM;
        imm_fmt_p0 = IMM_U; reg_write_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        src_a_p0 = SRC_A_PC; src_b_p0 = SRC_B_IMM;
        imm_fmt_p0 = IMM_U; reg_write_p0 = 1'b1;
      end
      OPC_JAL: begin
        src_a_p0 = SRC_A_PC; src_b_p0 = SRC_B_IMM; imm_fmt_p0 = IMM_J;
        jal_p0 = 1'b1; reg_write_p0 = 1'b1; wb_sel_p0 = WB_PC_PLUS;
      end
      OPC_JALR: begin
        src_b_p0 = SRC_B_IMM; rs1_used_p0 = 1'b1;
        jalr_p0 = 1'b1; reg_write_p0 = 1'b1; wb_sel_p0 = WB_PC_PLUS;
      end
      OPC_BRANCH: begin
        alu_op_p0 = ALU_SUB; imm_fmt_p0 = IMM_B; branch_p0 = 1'b1;
        rs1_used_p0 = 1'b1; rs2_used_p0 = 1'b1;
      end
      OPC_LOAD: begin
        src_b_p0 = SRC_B_IMM; rs1_used_p0 = 1'b1;
        mem_read_p0 = 1'b1; reg_write_p0 = 1'b1; wb_sel_p0 = WB_MEM;
      end
      OPC_STORE: begin
        src_b_p0 = SRC_B_IMM; imm_fmt_p0 = IMM_S; mem_write_p0 = 1'b1;
        rs1_used_p0 = 1'b1; rs2_used_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        src_b_p0 = SRC_B_IMM; rs1_used_p0 = 1'b1; reg_write_p0 = 1'b1;
        // funct7 is only an opcode field for shifts; otherwise it is imm[11:5].
        if (funct3_p0 == 3'b001)
          illegal_p0 = (funct7_p0 != F7_BASE);
        else if (funct3_p0 == 3'b101)
          illegal_p0 = (funct7_p0 != F7_BASE) && (funct7_p0 != F7_ALT);
        alu_op_p0 = base_op(funct3_p0, (funct3_p0 == 3'b101) && funct7_p0[5]);
      end
      OPC_OP: begin
        rs1_used_p0 = 1'b1; rs2_used_p0 = 1'b1; reg_write_p0 = 1'b1;
        if (funct7_p0 == F7_MULD)
          alu_op_p0 = muldiv_op(funct3_p0);
        else if (funct7_p0 == F7_BASE)
          alu_op_p0 = base_op(funct3_p0, 1'b0);
        else if ((funct7_p0 == F7_ALT) &&
                 ((funct3_p0 == 3'b000) || (funct3_p0 == 3'b101)))
          alu_op_p0 = base_op(funct3_p0, 1'b1);
        else
          illegal_p0 = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase

    // An illegal encoding issues as a bubble that only carries the flag,
    // and must not raise a hazard against a pending load.
    if (illegal_p0) begin
      alu_op_p0    = ALU_ADD;
      src_a_p0     = SRC_A_RS1;
      src_b_p0     = SRC_B_RS2;
      wb_sel_p0    = WB_ALU;
      mem_read_p0  = 1'b0;
      mem_write_p0 = 1'b0;
      reg_write_p0 = 1'b0;
      branch_p0    = 1'b0;
      jal_p0       = 1'b0;
      jalr_p0      = 1'b0;
      rs1_used_p0  = 1'b0;
      rs2_used_p0  = 1'b0;
    end
  end

  // Unused source fields are zeroed so execute forwarding never matches them.
  assign rs1_addr_p0 = rs1_used_p0  ? instruct_di[19:15] : 5'd0;
  assign rs2_addr_p0 = rs2_used_p0  ? instruct_di[24:20] : 5'd0;
  assign rd_p0       = reg_write_p0 ? instruct_di[11:7]  : 5'd0;
  assign imm_p0      = imm_gen(instruct_di, imm_fmt_p0);

  reg_file #(
    .DWIDTH  (DWIDTH),
    .NUM_REGS(NUM_REGS),
    .AW      (5)
  ) u_reg_file (
    .Clk_Core  (Clk_Core),
    .Rst_Core_N(Rst_Core_N),
    .rs1_addr  (rs1_addr_p0),
    .rs2_addr  (rs2_addr_p0),
    .rs1_data  (rs1_data_p0),
    .rs2_data  (rs2_data_p0),
    .wr_en     (wb_en_di),
    .wr_addr   (wb_rd_di),
    .wr_data   (wb_data_di)
  );

  // Stage p1: decode/execute register
  logic [DWIDTH-1:0]  pc_p1, pc_plus_p1, rs1_data_p1, rs2_data_p1;
  logic signed [31:0] imm_p1;
  logic [4:0]         rs1_addr_p1, rs2_addr_p1, rd_p1;
  alu_op_t            alu_op_p1;
  src_a_t             src_a_p1;
  src_b_t             src_b_p1;
  wb_sel_t            wb_sel_p1;
  logic [2:0]         funct3_p1;
  logic               mem_read_p1, mem_write_p1, reg_write_p1;
  logic               branch_p1, jal_p1, jalr_p1, illegal_p1;

  // A load in execute whose rd is needed now: hold fetch for one cycle.
  // Stall is dropped under flush because fetch would otherwise ignore the redirect.
  assign hazard_p0 = mem_read_p1 && (rd_p1 != 5'd0) &&
                     ((rs1_used_p0 && (rs1_addr_p0 == rd_p1)) ||
                      (rs2_used_p0 && (rs2_addr_p0 == rd_p1)));
  assign stall_do  = hazard_p0 && !flush_di;
  assign kill_p0   = flush_di || stall_do;

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      pc_p1        <= '0;
      pc_plus_p1   <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      rs1_addr_p1  <= '0;
      rs2_addr_p1  <= '0;
      rd_p1        <= '0;
      alu_op_p1    <= ALU_ADD;
      src_a_p1     <= SRC_A_RS1;
      src_b_p1     <= SRC_B_RS2;
      wb_sel_p1    <= WB_ALU;
      funct3_p1    <= '0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      reg_write_p1 <= 1'b0;
      branch_p1    <= 1'b0;
      jal_p1       <= 1'b0;
      jalr_p1      <= 1'b0;
      illegal_p1   <= 1'b0;
    end else begin
      pc_p1      <= pc_di;
      pc_plus_p1 <= pc_plus_di;
      if (kill_p0) begin
        rs1_data_p1  <= '0;
        rs2_data_p1  <= '0;
        imm_p1       <= '0;
        rs1_addr_p1  <= '0;
        rs2_addr_p1  <= '0;
        rd_p1        <= '0;
        alu_op_p1    <= ALU_ADD;
        src_a_p1     <= SRC_A_RS1;
        src_b_p1     <= SRC_B_RS2;
        wb_sel_p1    <= WB_ALU;
        funct3_p1    <= '0;
        mem_read_p1  <= 1'b0;
        mem_write_p1 <= 1'b0;
        reg_write_p1 <= 1'b0;
        branch_p1    <= 1'b0;
        jal_p1       <= 1'b0;
        jalr_p1      <= 1'b0;
        illegal_p1   <= 1'b0;
      end else begin
        rs1_data_p1  <= illegal_p0 ? '0 : rs1_data_p0;
        rs2_data_p1  <= illegal_p0 ? '0 : rs2_data_p0;
        imm_p1       <= illegal_p0 ? '0 : imm_p0;
        rs1_addr_p1  <= rs1_addr_p0;
        rs2_addr_p1  <= rs2_addr_p0;
        rd_p1        <= rd_p0;
        alu_op_p1    <= alu_op_p0;
        src_a_p1     <= src_a_p0;
        src_b_p1     <= src_b_p0;
        wb_sel_p1    <= wb_sel_p0;
        funct3_p1    <= illegal_p0 ? 3'b000 : funct3_p0;
        mem_read_p1  <= mem_read_p0;
        mem_write_p1 <= mem_write_p0;
        reg_write_p1 <= reg_write_p0;
        branch_p1    <= branch_p0;
        jal_p1       <= jal_p0;
        jalr_p1      <= jalr_p0;
        illegal_p1   <= illegal_p0;
      end
    end
  end

  assign pc_do        = pc_p1;
  assign pc_plus_do   = pc_plus_p1;
  assign rs1_data_do  = rs1_data_p1;
  assign rs2_data_do  = rs2_data_p1;
  assign imm_do       = imm_p1;
  assign rs1_addr_do  = rs1_addr_p1;
  assign rs2_addr_do  = rs2_addr_p1;
  assign rd_do        = rd_p1;
  assign alu_op_do    = alu_op_p1;
  assign alu_src_a_do = src_a_p1;
  assign alu_src_b_do = src_b_p1;
  assign wb_sel_do    = wb_sel_p1;
  assign mem_read_do  = mem_read_p1;
  assign mem_write_do = mem_write_p1;
  assign mem_size_do  = funct3_p1;
  assign br_funct3_do = funct3_p1;
  assign reg_write_do = reg_write_p1;
  assign branch_do    = branch_p1;
  assign jal_do       = jal_p1;
  assign jalr_do      = jalr_p1;
  assign illegal_do   = illegal_p1;

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- RV32IM decode stage; consumes fetch-stage pipeline outputs (pc, pc+4, instruction) and produces the stall that holds fetch.
- Decodes the instruction, generates the immediate, reads a 32x32 register file that the writeback stage writes.
- Detects load-use hazards and registers all control and operands into the decode/execute pipeline register, honouring execute-driven flush.

Parameters:
- DWIDTH, 32, datapath width.
- NUM_REGS, 32, architectural register count; x0 is hardwired to zero.

Ports:
- Clk_Core  input  1  core clock.
- Rst_Core_N  input  1  asynchronous active-low reset.
- instruct_di  input  32  instruction from fetch.
- pc_di  input  32  PC of instruct_di.
- pc_plus_di  input  32  pc_di+4.
- flush_di  input  1  branch/jump redirect from execute.
- stall_do  output  1  to fetch stall input. Combinational.
- wb_en_di  input  1  register file write enable.
- wb_rd_di  input  5  write address.
- wb_data_di  input  32  write data.
- pc_do, pc_plus_do  output  32 each  registered PC and PC+4.
- rs1_data_do, rs2_data_do  output  32 each  operands.
- imm_do  output  32  sign-extended immediate.
- rs1_addr_do, rs2_addr_do, rd_do  output  5 each  register addresses for execute forwarding.
- alu_op_do  output  5  alu_op_t.
- alu_src_a_do  output  2  RS1/PC/ZERO.
- alu_src_b_do  output  1  RS2/IMM.
- mem_read_do, mem_write_do  output  1 each  load/store.
- mem_size_do  output  3  funct3 of load/store.
- reg_write_do  output  1  writeback enable.
- wb_sel_do  output  2  ALU/MEM/PC_PLUS.
- branch_do, jal_do, jalr_do  output  1 each  control transfer.
- br_funct3_do  output  3  branch condition.
- illegal_do  output  1  unsupported opcode/funct encoding.

Behaviour:
- Reset: every registered output is 0. This makes the register a bubble, so stall_do=0. All register file entries are 0.
- Latency: one cycle. Fields decoded from instruct_di appear on the *_do outputs after the next posedge.
- Immediate formats:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All formats except U are sign-extended from the top bit.
- Opcodes supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - OP with funct7=0000001 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU by funct3.
  - SUB/SRA/SRAI are selected by funct7[5].
  - Any other opcode or funct7 produces a bubble with illegal_do=1.
- Register usage:
  - rs1 is used by all instructions except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Register file:
  - Two async read ports; synchronous write at posedge when wb_en_di=1 and wb_rd_di!=0.
  - Same-cycle bypass: a read address equal to a non-zero wb_rd_di with wb_en_di=1 returns wb_data_di.
  - x0 always reads 0.
  - Writes occur regardless of stall or flush.
- Load-use hazard:
  - hazard = mem_read_do & rd_do!=0 & ((rs1 used & rs1==rd_do) | (rs2 used & rs2==rd_do)).
  - stall_do = hazard & ~flush_di. Fetch gives stall priority over flush, so stall must be suppressed during a flush.
- Pipeline register update priority at each posedge:
  1. flush_di=1: load a bubble.
  2. Else stall_do=1: load a bubble. Fetch holds, so the same instruction is re-decoded next cycle; the stall lasts exactly one cycle.
  3. Else: load the decoded fields.
- Bubble definition:
  - reg_write, mem_read, mem_write, branch, jal, jalr and illegal are 0; rd_do=0.
  - pc_do and pc_plus_do still take the inputs.
  - Data outputs are don't-care and driven to 0.
- NOP input (0x00000013) decodes as ADDI x0,x0,0: reg_write_do=1, rd_do=0.
- Reset mid-stall: outputs clear immediately and stall_do drops in the same cycle.

Decomposition:
- Package rv32_pkg holds:
  - Opcode constants and INSTR_NOP.
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, PASS_B.
  - src_a_t and wb_sel_t enums.
  - The imm_gen function.
- Sub-module reg_file: 2R1W register file with write-bypass and x0 hardwired.

Test Plan:
- Reset then instruct_di=0x00500093 (addi x1,x0,5) -> next cycle: imm_do=5, alu_op_do=ADD, alu_src_b_do=IMM, reg_write_do=1, rd_do=1, stall_do=0.
- Write x2=0xDEADBEEF via wb port while decoding add x3,x2,x2 (0x002101B3) in the same cycle -> rs1_data_do=rs2_data_do=0xDEADBEEF (bypass).
- lw x5,0(x1), then add x6,x5,x0 held at input -> stall_do=1 for exactly one cycle; bubble issued; add issues the following cycle with rs1_addr_do=5.
- Same load-use pair with flush_di=1 in the hazard cycle -> stall_do=0; bubble loaded.
- beq x0,x0,-8 (0xFE000CE3) -> branch_do=1, imm_do=0xFFFFFFF8, br_funct3_do=0. Then mul x7,x1,x2 (0x022083B3) -> alu_op_do=MUL.
- Opcode 0x0000007F -> illegal_do=1, reg_write_do=0, mem_write_do=0. Write to x0 via wb port -> x0 still reads 0.
